// File: rtl/up_counter_mod.sv
// Programmable-modulo up counter with enable, synchronous clear/load, terminal count,
// a one-cycle wrap pulse and a sticky overflow flag; optionally saturating at limit.
module up_counter_mod #(
   parameter int WIDTH    = 7,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

   logic [WIDTH-1:0] count_r;
   logic             wrap_r;
   logic             ovf_r;
   logic [WIDTH-1:0] count_nxt_s;
   logic             wrap_nxt_s;
   logic             ovf_nxt_s;

   // Next-state selection with priority clr > load > en > hold
   always_comb begin
      count_nxt_s = count_r;
      wrap_nxt_s  = 1'b0;
      ovf_nxt_s   = ovf_r;
      if (clr) begin
         count_nxt_s = ZERO;
         ovf_nxt_s   = 1'b0;
      end else if (load) begin
         count_nxt_s = load_val;
      end else if (en) begin
         if (SATURATE) begin
            // Parked at limit, or at all-ones when started above limit
            if ((count_r == limit) || (count_r == ALL_ONES)) begin
               count_nxt_s = count_r;
            end else begin
               count_nxt_s = count_r + ONE;
            end
         end else begin
            if (count_r == limit) begin
               count_nxt_s = ZERO;
               wrap_nxt_s  = 1'b1;
               ovf_nxt_s   = 1'b1;
            end else if (count_r == ALL_ONES) begin
               // Natural rollover when counting from above a lowered limit
               count_nxt_s = ZERO;
               wrap_nxt_s  = 1'b1;
               ovf_nxt_s   = 1'b1;
            end else begin
               count_nxt_s = count_r + ONE;
            end
         end
      end else begin
         count_nxt_s = count_r;
      end
   end

   // State registers with asynchronous active-low reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= ZERO;
         wrap_r  <= 1'b0;
         ovf_r   <= 1'b0;
      end else begin
         count_r <= count_nxt_s;
         wrap_r  <= wrap_nxt_s;
         ovf_r   <= ovf_nxt_s;
      end
   end

   assign count = count_r;
   assign wrap  = wrap_r;
   assign ovf   = ovf_r;
   assign tc    = (count_r == limit);

endmodule

// File: tb/tb_up_counter_mod.sv
// Directed self-checking bench for up_counter_mod: a wrapping and a saturating
// instance share one stimulus stream; each task checks its own scenario.
module tb_up_counter_mod;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       clr;
   logic       load;
   logic [6:0] load_val;
   logic [6:0] limit;
   logic [6:0] count;
   logic       tc;
   logic       wrap;
   logic       ovf;
   logic [6:0] count_sat;
   logic       tc_sat;
   logic       wrap_sat;
   logic       ovf_sat;

   int n_checks;
   int n_fail;

   up_counter_mod #(.WIDTH(7), .SATURATE(1'b0)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
      .load_val(load_val), .limit(limit),
      .count(count), .tc(tc), .wrap(wrap), .ovf(ovf)
   );

   up_counter_mod #(.WIDTH(7), .SATURATE(1'b1)) dut_sat (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .load(load),
      .load_val(load_val), .limit(limit),
      .count(count_sat), .tc(tc_sat), .wrap(wrap_sat), .ovf(ovf_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      en = 1'b0; clr = 1'b0; load = 1'b0; load_val = 7'd0;
   endtask

   task automatic test_reset();
      idle_inputs();
      limit = 7'd5;
      rst_n = 1'b0;
      #12;
      n_checks++;
      if ({count, tc, wrap, ovf} !== {7'd0, 1'b0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL reset_state: count=%0d tc=%b wrap=%b ovf=%b expected 0 0 0 0", count, tc, wrap, ovf);
      end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_checks++;
         if ({count, tc, wrap, ovf} !== {7'd0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_hold[%0d]: count=%0d tc=%b wrap=%b ovf=%b expected 0 0 0 0", i, count, tc, wrap, ovf);
         end
      end
   endtask

   task automatic test_count_wrap();
      int exp_c[8] = '{1, 2, 3, 4, 5, 0, 1, 2};
      limit = 7'd5;
      en    = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         n_checks++;
         if ({count, tc, wrap, ovf} !== {7'(exp_c[i]), exp_c[i] == 5, i == 5, i >= 5}) begin
            n_fail++;
            $display("FAIL count_wrap[%0d]: count=%0d tc=%b wrap=%b ovf=%b expected %0d %b %b %b",
                     i, count, tc, wrap, ovf, exp_c[i], exp_c[i] == 5, i == 5, i >= 5);
         end
      end
      en = 1'b0;
      step();
      n_checks++;
      if ({count, wrap, ovf} !== {7'd2, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL count_hold: count=%0d wrap=%b ovf=%b expected 2 0 1", count, wrap, ovf);
      end
   endtask

   task automatic test_load();
      int exp_c[4] = '{3, 4, 5, 0};
      clr = 1'b1;
      step();
      clr = 1'b0;
      n_checks++;
      if ({count, ovf} !== {7'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL load_preclear: count=%0d ovf=%b expected 0 0", count, ovf);
      end
      load = 1'b1; load_val = 7'd3; en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         load = 1'b0;
         n_checks++;
         if ({count, wrap, ovf} !== {7'(exp_c[i]), i == 3, i == 3}) begin
            n_fail++;
            $display("FAIL load_seq[%0d]: count=%0d wrap=%b ovf=%b expected %0d %b %b",
                     i, count, wrap, ovf, exp_c[i], i == 3, i == 3);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_clr_load();
      clr = 1'b1; load = 1'b1; load_val = 7'd6; en = 1'b1;
      step();
      idle_inputs();
      n_checks++;
      if ({count, wrap, ovf} !== {7'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL clr_over_load: count=%0d wrap=%b ovf=%b expected 0 0 0", count, wrap, ovf);
      end
   endtask

   task automatic test_limit_lowered();
      limit = 7'd10; load = 1'b1; load_val = 7'd5;
      step();
      load = 1'b0; limit = 7'd3; en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks++;
         if ({count, tc, wrap} !== {7'(6 + i), 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL limit_lowered[%0d]: count=%0d tc=%b wrap=%b expected %0d 0 0", i, count, tc, wrap, 6 + i);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_saturate();
      int exp_c[10] = '{1, 2, 3, 4, 4, 4, 4, 4, 4, 4};
      clr = 1'b1;
      step();
      clr = 1'b0; limit = 7'd4; en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         n_checks++;
         if ({count_sat, tc_sat, wrap_sat, ovf_sat} !== {7'(exp_c[i]), i >= 3, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL saturate[%0d]: count=%0d tc=%b wrap=%b ovf=%b expected %0d %b 0 0",
                     i, count_sat, tc_sat, wrap_sat, ovf_sat, exp_c[i], i >= 3);
         end
      end
      load = 1'b1; load_val = 7'd127; limit = 7'd5;
      step();
      load = 1'b0;
      step();
      n_checks++;
      if ({count_sat, wrap_sat, ovf_sat} !== {7'd127, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL saturate_allones: count=%0d wrap=%b ovf=%b expected 127 0 0", count_sat, wrap_sat, ovf_sat);
      end
      en = 1'b0;
   endtask

   task automatic test_back_to_back();
      clr = 1'b1;
      step();
      clr = 1'b0; limit = 7'd0; en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if ({count, tc, wrap, ovf} !== {7'd0, 1'b1, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL back_to_back[%0d]: count=%0d tc=%b wrap=%b ovf=%b expected 0 1 1 1", i, count, tc, wrap, ovf);
         end
      end
      en = 1'b0;
   endtask

   task automatic test_async_reset();
      limit = 7'd5; load = 1'b1; load_val = 7'd9;
      step();
      load = 1'b0;
      n_checks++;
      if (count !== 7'd9) begin
         n_fail++;
         $display("FAIL async_preload: count=%0d expected 9", count);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if ({count, wrap, ovf} !== {7'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL async_reset: count=%0d wrap=%b ovf=%b expected 0 0 0", count, wrap, ovf);
      end
      en = 1'b1;
      #2;
      rst_n = 1'b1;
      step();
      n_checks++;
      if (count !== 7'd1) begin
         n_fail++;
         $display("FAIL async_resume: count=%0d expected 1", count);
      end
      en = 1'b0; load = 1'b1; load_val = 7'd127;
      step();
      load = 1'b0; en = 1'b1;
      step();
      n_checks++;
      if ({count, tc, wrap, ovf} !== {7'd0, 1'b0, 1'b1, 1'b1}) begin
         n_fail++;
         $display("FAIL rollover: count=%0d tc=%b wrap=%b ovf=%b expected 0 0 1 1", count, tc, wrap, ovf);
      end
      step();
      n_checks++;
      if ({count, wrap, ovf} !== {7'd1, 1'b0, 1'b1}) begin
         n_fail++;
         $display("FAIL rollover_after: count=%0d wrap=%b ovf=%b expected 1 0 1", count, wrap, ovf);
      end
      en = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b1;
      limit    = 7'd5;
      idle_inputs();
      test_reset();
      test_count_wrap();
      test_load();
      test_clr_load();
      test_limit_lowered();
      test_saturate();
      test_back_to_back();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
